// File: rtl/aibio_outclk_phsel_pkg.sv
// Shared types and helpers for the output-clock phase-select sequencer.
// Phase count, state encoding and ring-direction decision live here.
package aibio_outclk_phsel_pkg;

    localparam int NPH  = 16;
    localparam int PH_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        SETTLE,
        DONE
    } phsel_st_e;

    typedef enum logic [1:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DN
    } ph_dir_e;

    // Shorter way around the ring; a half-ring tie resolves upward.
    function automatic ph_dir_e ph_dir(input logic [PH_W-1:0] cur,
                                       input logic [PH_W-1:0] tgt);
        logic [PH_W-1:0] diff;
        diff = tgt - cur;
        if (diff == '0) begin
            return DIR_NONE;
        end else if (diff <= PH_W'(NPH / 2)) begin
            return DIR_UP;
        end else begin
            return DIR_DN;
        end
    endfunction

endpackage

// File: rtl/aibio_phsel_settle_cnt.sv
// Loadable down-counter timing the settle interval after each select update.
// Saturates at zero and flags it so the sequencer can branch on the same cycle.
module aibio_phsel_settle_cnt #(
    parameter int SETTLE_CYC = 8,
    localparam int CW        = $clog2(SETTLE_CYC + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          dec,
    input  logic [CW-1:0] load_val,
    output logic [CW-1:0] cnt,
    output logic          zero
);

    logic [CW-1:0] cnt_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - CW'(1);
        end
    end

    assign cnt  = cnt_reg;
    assign zero = (cnt_reg == '0);

endmodule

// File: rtl/aibio_outclk_phsel_ctrl.sv
// Walks the 16-phase output-clock mux select toward a requested phase, one
// phase per step with a settle wait after each update, or in one load when asked.
module aibio_outclk_phsel_ctrl
    import aibio_outclk_phsel_pkg::*;
#(
    parameter int SETTLE_CYC = 8
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_sel_vld,
    input  logic [PH_W-1:0] i_target_ph,
    input  logic            i_direct_ld,
    input  logic            i_abort,
    output logic [PH_W-1:0] o_clksel,
    output logic            o_busy,
    output logic            o_done
);

    localparam int CW = $clog2(SETTLE_CYC + 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);

    phsel_st_e       state_reg;
    phsel_st_e       state_next;
    logic [PH_W-1:0] target_reg;
    logic            direct_reg;
    logic            abort_reg;
    logic [PH_W-1:0] clksel_reg;
    logic [PH_W-1:0] clksel_next;
    logic            busy_reg;
    logic            done_reg;

    logic            capture;
    logic            step_en;
    logic            cnt_load;
    logic            cnt_dec;
    logic            cnt_zero;
    logic [CW-1:0]   cnt_val;
    logic            abort_pend;
    ph_dir_e         dir;

    aibio_phsel_settle_cnt #(
        .SETTLE_CYC (SETTLE_CYC)
    ) u_settle_cnt (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (SETTLE_LD),
        .cnt      (cnt_val),
        .zero     (cnt_zero)
    );

    assign dir        = ph_dir(clksel_reg, target_reg);
    assign abort_pend = abort_reg | i_abort;

    always_comb begin
        state_next = state_reg;
        capture    = 1'b0;
        step_en    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (i_sel_vld) begin
                    capture = 1'b1;
                    if ((i_target_ph == clksel_reg) && !i_direct_ld) begin
                        state_next = DONE;
                    end else begin
                        state_next = STEP;
                    end
                end
            end
            STEP: begin
                step_en    = 1'b1;
                cnt_load   = 1'b1;
                state_next = SETTLE;
            end
            SETTLE: begin
                cnt_dec = 1'b1;
                if (cnt_zero) begin
                    // An abort only takes effect once the running settle has elapsed.
                    if ((clksel_reg == target_reg) || abort_pend) begin
                        state_next = DONE;
                    end else begin
                        state_next = STEP;
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_comb begin
        clksel_next = clksel_reg;
        if (step_en) begin
            if (direct_reg) begin
                clksel_next = target_reg;
            end else begin
                case (dir)
                    DIR_UP:  clksel_next = clksel_reg + PH_W'(1);
                    DIR_DN:  clksel_next = clksel_reg - PH_W'(1);
                    default: clksel_next = clksel_reg;
                endcase
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg  <= IDLE;
            target_reg <= '0;
            direct_reg <= 1'b0;
            abort_reg  <= 1'b0;
            clksel_reg <= '0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            clksel_reg <= clksel_next;
            busy_reg   <= (state_reg != IDLE);
            done_reg   <= (state_reg == DONE);
            if (capture) begin
                target_reg <= i_target_ph;
                direct_reg <= i_direct_ld;
            end
            if (state_reg == IDLE) begin
                abort_reg <= 1'b0;
            end else if (((state_reg == STEP) || (state_reg == SETTLE)) && i_abort) begin
                abort_reg <= 1'b1;
            end
        end
    end

    assign o_clksel = clksel_reg;
    assign o_busy   = busy_reg;
    assign o_done   = done_reg;

    logic unused_cnt;
    assign unused_cnt = ^cnt_val;

endmodule

// File: tb/tb_aibio_outclk_phsel_ctrl.sv
// Scoreboard bench for the phase-select sequencer: a ring-walk model queues
// expected select changes and the done pulse, the monitor pops and compares them.
module tb_aibio_outclk_phsel_ctrl;

    localparam int S = 8;

    logic       i_clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_sel_vld = 1'b0;
    logic [3:0] i_target_ph = 4'd0;
    logic       i_direct_ld = 1'b0;
    logic       i_abort = 1'b0;
    logic [3:0] o_clksel;
    logic       o_busy;
    logic       o_done;

    always #5 i_clk = ~i_clk;

    aibio_outclk_phsel_ctrl #(.SETTLE_CYC(S)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_sel_vld   (i_sel_vld),
        .i_target_ph (i_target_ph),
        .i_direct_ld (i_direct_ld),
        .i_abort     (i_abort),
        .o_clksel    (o_clksel),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    typedef struct {
        int kind;     // 0 = select change, 1 = done pulse
        int edge_no;
        int val;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cur_m = 0;

    task automatic chk(input string tag, input int obs, input int exp_v);
        n_cmp++;
        if (obs != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int kind, input int edge_no, input int val);
        exp_t x;
        x.kind = kind;
        x.edge_no = edge_no;
        x.val = val;
        sb.push_back(x);
    endtask

    // One request; edges are numbered from the sampling edge (edge 0).
    task automatic run_req(input int tgt, input bit dl, input int ab_edge,
                           input bit ign, input int rst_edge);
        int   c;
        int   k;
        int   done_e;
        int   prev;
        bit   up;
        bit   busy_seen;
        bit   finished;
        exp_t x;
        k = 0;
        c = cur_m;
        if (dl) begin
            k = 1;
            c = tgt;
            push(0, 1, tgt);
        end else if (tgt != cur_m) begin
            up = ((tgt - cur_m) & 15) <= 8;
            while (c != tgt) begin
                k++;
                c = up ? ((c + 1) & 15) : ((c + 15) & 15);
                push(0, 1 + (k - 1) * (S + 1), c);
                if (ab_edge > 0 && ab_edge <= k * (S + 1)) break;
            end
        end
        done_e = k * (S + 1) + 1;
        push(1, done_e, 1);

        @(negedge i_clk);
        i_sel_vld = 1'b1;
        i_target_ph = 4'(tgt);
        i_direct_ld = dl;
        @(posedge i_clk);
        #1;
        i_sel_vld = 1'b0;
        i_direct_ld = 1'b0;
        prev = int'(o_clksel);
        busy_seen = 1'b0;
        finished = 1'b0;
        for (int e = 1; e <= 120 && !finished; e++) begin
            @(posedge i_clk);
            #1;
            if (int'(o_clksel) != prev) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun_sel", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("sel_val", int'(o_clksel), x.val);
                    chk("sel_edge", e, x.edge_no);
                end
                prev = int'(o_clksel);
            end
            if (o_done) begin
                if (sb.size() == 0) begin
                    chk("sb_underrun_done", 1, 0);
                end else begin
                    x = sb.pop_front();
                    chk("done_edge", e, x.edge_no);
                end
            end
            if (o_busy) begin
                busy_seen = 1'b1;
            end else if (busy_seen) begin
                chk("busy_fall", e, done_e + 1);
                finished = 1'b1;
            end
            if (e == rst_edge) begin
                #2 i_rst_n = 1'b0;
                #1;
                chk("rst_sel", int'(o_clksel), 0);
                chk("rst_busy", int'(o_busy), 0);
                chk("rst_done", int'(o_done), 0);
                repeat (3) begin
                    @(posedge i_clk);
                    #1;
                    chk("rst_no_done", int'(o_done), 0);
                end
                @(negedge i_clk);
                i_rst_n = 1'b1;
                sb.delete();
                cur_m = 0;
                return;
            end
            i_abort = (e + 1 == ab_edge);
            if (ign) begin
                i_sel_vld = (e + 1 == 5);
                if (e + 1 == 5) i_target_ph = 4'd15;
            end
        end
        i_abort = 1'b0;
        i_sel_vld = 1'b0;
        if (!finished) chk("timeout", 0, 1);
        chk("sb_empty", sb.size(), 0);
        chk("final_sel", int'(o_clksel), c);
        $display("req tgt=%0d dl=%0d ab=%0d -> sel=%0d steps=%0d done_edge=%0d",
                 tgt, dl, ab_edge, o_clksel, k, done_e);
        sb.delete();
        cur_m = c;
    endtask

    initial begin
        repeat (2) @(posedge i_clk);
        #1;
        chk("reset_sel", int'(o_clksel), 0);
        chk("reset_busy", int'(o_busy), 0);
        chk("reset_done", int'(o_done), 0);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        @(posedge i_clk);

        run_req(3, 1'b0, 0, 1'b0, 0);    // up walk 1,2,3
        run_req(1, 1'b0, 0, 1'b0, 0);    // down walk
        run_req(14, 1'b0, 0, 1'b0, 0);   // down walk across wrap
        run_req(2, 1'b1, 0, 1'b0, 0);    // direct load
        run_req(6, 1'b0, 0, 1'b0, 12);   // reset mid-walk
        run_req(8, 1'b0, 0, 1'b0, 0);    // half-ring tie goes up
        run_req(5, 1'b0, 0, 1'b0, 0);
        run_req(5, 1'b0, 0, 1'b0, 0);    // zero-step request
        run_req(0, 1'b1, 0, 1'b0, 0);
        run_req(11, 1'b1, 0, 1'b0, 0);   // direct load 0 -> 11
        run_req(0, 1'b0, 0, 1'b0, 0);    // up walk across wrap
        run_req(6, 1'b0, 12, 1'b1, 0);   // abort plus ignored request while busy

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
